// File: rtl/bcd_display_formatter.sv
`default_nettype none
// =============================================================================
// bcd_display_formatter : sequential double-dabble binary-to-BCD converter with
// saturation and leading-zero blanking, feeding a 4-digit 7-segment multiplexer.
// Rev 1.0
// =============================================================================
module bcd_display_formatter #(
  parameter int BIN_WIDTH = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 start,
  input  logic                 lz_blank_en,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          data_out,
  output logic [3:0]           blank_out,
  output logic                 overflow
);

  localparam logic [BIN_WIDTH-1:0] C_MAX      = BIN_WIDTH'(MAX_VALUE);
  localparam logic [3:0]           C_CNT_INIT = 4'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [15:0]          scratch_q, scratch_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 lz_q, lz_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          data_q, data_d;
  logic [3:0]           blank_q, blank_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  logic [15:0]          w_adj;
  logic [3:0]           w_lz_mask;
  logic                 w_d3z, w_d2z, w_d1z;

  // Add-3 correction per nibble; nibbles never carry into each other.
  always_comb begin
    w_adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_d3z     = (scratch_q[15:12] == 4'd0);
  assign w_d2z     = (scratch_q[11:8]  == 4'd0);
  assign w_d1z     = (scratch_q[7:4]   == 4'd0);
  assign w_lz_mask = {w_d3z, w_d3z & w_d2z, w_d3z & w_d2z & w_d1z, 1'b0};

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    lz_d       = lz_q;
    ovf_d      = ovf_q;
    data_d     = data_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d     = (bin_in > C_MAX) ? C_MAX : bin_in;
          ovf_d     = (bin_in > C_MAX);
          lz_d      = lz_blank_en;
          scratch_d = 16'h0000;
          cnt_d     = C_CNT_INIT;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scratch_d, bin_d} = {w_adj, bin_q} << 1;
        if (cnt_q == 4'd0) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_LOAD: begin
        data_d     = scratch_q;
        overflow_d = ovf_q;
        blank_d    = lz_q ? w_lz_mask : 4'b0000;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      scratch_q  <= 16'h0000;
      cnt_q      <= 4'd0;
      lz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      data_q     <= 16'h0000;
      blank_q    <= 4'b1111;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      lz_q       <= lz_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign data_out  = data_q;
  assign blank_out = blank_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_formatter.sv
`default_nettype none
// =============================================================================
// tb_bcd_display_formatter : directed + random checks of the BCD formatter
// against a decimal-arithmetic reference model. Rev 1.0
// =============================================================================
module tb_bcd_display_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin_in;
  logic        start;
  logic        lz_blank_en;
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic [3:0]  blank_out;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int prev_c;
  int npulse;
  int stray;

  bcd_display_formatter #(.BIN_WIDTH(14), .MAX_VALUE(9999)) dut (
    .clk         (clk),
    .rst         (rst),
    .bin_in      (bin_in),
    .start       (start),
    .lz_blank_en (lz_blank_en),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .blank_out   (blank_out),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed='%s' expected='%s'", tag, obs, exp);
    end
  endtask

  // Reference: a digit is blank iff blanking is on and the value is below 10^k.
  function automatic void model(input int v, input bit lz, output logic [15:0] d,
                                output logic [3:0] b, output logic o);
    int s;
    s = (v > 9999) ? 9999 : v;
    d = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    o = (v > 9999);
    b = 4'b0000;
    if (lz) begin
      b[3] = (s < 1000);
      b[2] = (s < 100);
      b[1] = (s < 10);
    end
  endfunction

  function automatic string shown(input logic [15:0] d, input logic [3:0] b);
    string s;
    s = "";
    for (int k = 3; k >= 0; k--) begin
      if (b[k]) s = {s, " "};
      else      s = {s, $sformatf("%0d", d[4*k +: 4])};
    end
    return s;
  endfunction

  task automatic convert(input int v, input bit lz, input bit disturb);
    logic [15:0] ed;
    logic [3:0]  eb;
    logic        eo;
    int          lat;
    int          s;
    bit          seen;
    model(v, lz, ed, eb, eo);
    s = (v > 9999) ? 9999 : v;
    @(negedge clk);
    bin_in = 14'(v); lz_blank_en = lz; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("busy_after_accept v=%0d", v), 32'(busy), 32'd1);
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (disturb) begin
        start       = (c == 5);
        bin_in      = (c == 5) ? 14'd9876 : 14'($urandom);
        lz_blank_en = 1'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; lat = c; end
    end
    start = 1'b0;
    chk($sformatf("latency v=%0d", v), 32'(lat), 32'd15);
    chk($sformatf("busy_at_done v=%0d", v), 32'(busy), 32'd0);
    chk($sformatf("data v=%0d lz=%0d", v, lz), 32'(data_out), 32'(ed));
    chk($sformatf("blank v=%0d lz=%0d", v, lz), 32'(blank_out), 32'(eb));
    chk($sformatf("overflow v=%0d", v), 32'(overflow), 32'(eo));
    chk_str($sformatf("display v=%0d lz=%0d", v, lz), shown(data_out, blank_out),
            lz ? $sformatf("%4d", s) : $sformatf("%04d", s));
    @(posedge clk); #1;
    chk($sformatf("done_width v=%0d", v), 32'(done), 32'd0);
    chk($sformatf("data_hold v=%0d", v), 32'({data_out, blank_out}), 32'({ed, eb}));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin_in = '0; lz_blank_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data_out), 32'h0000);
    chk("rst_blank", 32'(blank_out), 32'hF);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk); rst = 1'b0;

    convert(1234, 1'b0, 1'b0);
    convert(42, 1'b1, 1'b0);
    convert(0, 1'b1, 1'b0);
    convert(7, 1'b1, 1'b0);
    convert(305, 1'b1, 1'b0);
    convert(42, 1'b0, 1'b0);
    convert(9999, 1'b0, 1'b0);
    convert(10000, 1'b1, 1'b0);
    convert(16383, 1'b0, 1'b0);
    convert(5, 1'b1, 1'b0);

    // Busy protection: a mid-flight start and a noisy bin_in must not leak in.
    convert(1234, 1'b0, 1'b1);
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) stray++;
    end
    chk("no_queued_start", 32'(stray), 32'd0);

    // start held high: one done every 16 cycles.
    @(negedge clk);
    bin_in = 14'd77; lz_blank_en = 1'b0; start = 1'b1;
    prev_c = -1; npulse = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (prev_c >= 0) chk("b2b_period", 32'(c - prev_c), 32'd16);
        chk("b2b_data", 32'(data_out), 32'h0077);
        prev_c = c;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 32'(npulse), 32'd4);
    for (int c = 0; c < 40 && busy; c++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_drained", 32'(busy), 32'd0);

    // Reset at cycle 7 of a conversion.
    @(negedge clk);
    bin_in = 14'd4321; lz_blank_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_blank", 32'(blank_out), 32'hF);
    chk("midrst_data", 32'(data_out), 32'h0000);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk); rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    chk("midrst_no_done", 32'(stray), 32'd0);
    convert(8, 1'b0, 1'b0);

    // rst and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; bin_in = 14'd555;
    @(posedge clk); #1;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_blank", 32'(blank_out), 32'hF);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    // Random sweep, biased to include boundary neighbourhoods.
    for (int i = 0; i < 400; i++) begin
      int v;
      case (i % 8)
        0:       v = $urandom_range(9990, 10010);
        1:       v = $urandom_range(0, 15);
        default: v = $urandom_range(0, 16383);
      endcase
      convert(v, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
